read_controller: RTL and testbench
==================================

# read_controller

Memory-to-byte-stream read engine, the egress counterpart of the write controller. On a start pulse it reads `S1_LENGTH` consecutive 2048-bit words from the frame buffer, beginning at address 0. It serializes each word into 256 bytes on a valid/ready byte stream. It sits between the frame-buffer read port and the downstream byte consumer.

## Interface
- `S1_LENGTH`, 3444: words per frame; legal range 1..4096.
- `WORD_W`, 2048: memory word width; must be a multiple of 8.
- `clk_in`  input  1  sole clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  one-cycle request to begin a frame; honoured only in IDLE.
- `addr`  output  12  frame-buffer read address.
- `clk_read`  output  1  read strobe; the memory returns `p_data` on the cycle after it is high.
- `p_data`  input  WORD_W  read data from the frame buffer.
- `s_data`  output  8  byte out.
- `s_valid`  output  1  `s_data` is valid.
- `s_ready`  input  1  consumer accepts the byte; a transfer happens when `s_valid && s_ready`.
- `s_last`  output  1  high with the final byte of the final word of a frame.
- `busy`  output  1  high in any state other than IDLE.
- `done`  output  1  one-cycle pulse at end of frame.

## Operation
- FSM states: IDLE, FETCH, WAIT, SHIFT, DONE.
- **IDLE:** when `start` is high, go to FETCH with `addr`=0.
- **FETCH:** one cycle. `clk_read`=1 and `addr` is held. Next state is WAIT.
- **WAIT:** one cycle. `p_data` is valid and is captured into the internal word register at the end of the cycle. Byte index is cleared to 0. Next state is SHIFT.
- **SHIFT:**
  - `s_valid`=1 and `s_data` = word[8·idx+7 : 8·idx]. Bytes go out LSB first: byte 0 is bits [7:0].
  - Each transfer increments `idx`, an 8-bit counter for the default `WORD_W`, sized to hold WORD_W/8−1.
  - On transfer of the last byte (idx = WORD_W/8−1):
    - If `addr` = S1_LENGTH−1, go to DONE.
    - Otherwise `addr`←`addr`+1 and go to FETCH.
- **DONE:** one cycle with `done`=1 and `addr`←0. Next state is IDLE.
- `start` is ignored in every state except IDLE. It is not queued.
- Stream rule: while `s_valid && !s_ready`, `s_data` and `s_last` hold stable. `s_valid` never drops without a transfer.
- `s_last` = SHIFT && `addr`=S1_LENGTH−1 && idx=last.
- `addr` arithmetic is 12-bit unsigned. It never exceeds S1_LENGTH−1.

## Timing
- All outputs are registered. Reset values:
  - `addr`=0, `clk_read`=0, `s_data`=0, `s_valid`=0, `s_last`=0, `busy`=0, `done`=0.
  - State = IDLE and idx = 0.
- `start` sampled at cycle T:
  - FETCH at T+1.
  - WAIT at T+2.
  - First `s_valid` at T+3.
- With `s_ready` held high, one byte transfers per cycle.
- Between words, `s_valid` is low for 2 cycles (FETCH, WAIT).
- A frame with constant `s_ready` takes S1_LENGTH·(WORD_W/8 + 2) + 1 cycles from FETCH through DONE.
- `reset` overrides everything, including mid-frame and simultaneous `start`. The next cycle is IDLE with all outputs at reset values. An aborted frame produces no `done`.
- `start` and last-byte transfer in the same cycle: `start` is ignored, because the FSM is not in IDLE.

## Configuration
- `READ_CTRL_CONT_EN`
- **Defined (continuous mode):**
  - After the last byte of word S1_LENGTH−1, `addr` wraps to 0 and the FSM goes directly to FETCH.
  - `done` pulses for one cycle concurrently with that FETCH cycle.
  - `s_last` behaves as above.
  - Streaming continues until `reset`. DONE is unused.
- **Undefined:** single-frame behaviour as described above.

## Test plan
- **Single frame (S1_LENGTH=2, `s_ready`=1, word k = byte pattern (k·16+i) mod 256):** expect 512 bytes, in-order and LSB first; `s_last` only on byte 511; one `done` pulse; then `busy`=0.
- **Backpressure (`s_ready` toggled 1,0,0,1 …):** `s_data` is stable while stalled; no byte is dropped or duplicated; byte count = 256·S1_LENGTH.
- **Latency:** `start` at cycle 10 → `clk_read`=1 with `addr`=0 at cycle 11 → `s_valid` rises at cycle 13.
- **Wrap boundary (S1_LENGTH=3):** addresses 0, 1, 2 are read; `addr` returns to 0 after DONE. With `READ_CTRL_CONT_EN`, the next FETCH is at `addr`=0 with no IDLE cycle, and `done` pulses each frame.
- **Reset mid-frame (assert at byte 100 of word 1):** the next cycle has all outputs 0 and state IDLE, with no `done`. A fresh `start` restarts at `addr`=0, byte 0.
- **`start` while busy:** a pulse during SHIFT is ignored; exactly one frame is produced.

Source files
------------

// File: rtl/read_controller.sv
// read_controller: frame-buffer to byte-stream read engine.
// On start, reads S1_LENGTH words (addresses 0..S1_LENGTH-1) and emits each word
// as WORD_W/8 bytes, LSB first, on a valid/ready stream.
//
// Ports:
//   clk_in, reset       sole clock, synchronous active-high reset
//   start               one-cycle frame request, honoured only in IDLE
//   addr, clk_read      frame-buffer read address and read strobe
//                       (the memory returns p_data one cycle after the strobe)
//   p_data              frame-buffer read data
//   s_data, s_valid,    byte stream out; a byte transfers when s_valid && s_ready
//   s_ready, s_last     s_last marks the final byte of the final word of a frame
//   busy, done          busy in any non-IDLE state; done pulses once per frame
//
// Optional build macro READ_CTRL_CONT_EN: continuous mode. After the last word
// the address wraps to 0 and fetching restarts immediately. done pulses alongside
// that refetch, and DONE is never entered.
//
// Latency: start -> clk_read 1 cycle; first s_valid 3 cycles after start.
// Between words s_valid drops for 2 cycles (FETCH, WAIT).
// Backpressure: s_data/s_last hold while s_valid && !s_ready.

module read_controller #(
  parameter int S1_LENGTH = 3444,  // words per frame, 1..4096
  parameter int WORD_W    = 2048   // memory word width, multiple of 8
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  output logic [11:0]       addr,
  output logic              clk_read,
  input  logic [WORD_W-1:0] p_data,
  output logic [7:0]        s_data,
  output logic              s_valid,
  input  logic              s_ready,
  output logic              s_last,
  output logic              busy,
  output logic              done
);

  localparam int BYTES = WORD_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTES - 1);
  localparam logic [11:0]      ADDR_LAST = 12'(S1_LENGTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]  idx, idx_next;
  logic [11:0]       addr_next;
  logic [WORD_W-1:0] word_q, word_next;
  logic [7:0]        s_data_next;
  logic              xfer;
  logic              last_byte;
  logic              last_word;
`ifdef READ_CTRL_CONT_EN
  logic              frame_end;
`endif

  // s_valid is exactly "state is SHIFT" (registered from state_next), so a
  // transfer is SHIFT with the consumer ready.
  assign xfer      = (state == ST_SHIFT) && s_ready;
  assign last_byte = (idx == IDX_LAST);
  assign last_word = (addr == ADDR_LAST);

  // State register. The datapath word register has no reset: it is always
  // reloaded in WAIT before any of its bytes are presented.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_ff @(posedge clk_in) begin
    word_q <= word_next;
  end

  // Next-state and datapath next values.
  // word_q holds the not-yet-presented bytes, already shifted so the next byte
  // sits in [7:0]. This avoids a wide byte-select mux on the idx counter.
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    addr_next   = addr;
    word_next   = word_q;
    s_data_next = s_data;
`ifdef READ_CTRL_CONT_EN
    frame_end   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FETCH;
          addr_next  = '0;
        end
      end
      ST_FETCH: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // p_data is valid this cycle: byte 0 goes straight to the output
        // register, and the remainder is kept for the following bytes.
        s_data_next = p_data[7:0];
        word_next   = p_data >> 8;
        idx_next    = '0;
        state_next  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (xfer) begin
          if (last_byte) begin
            if (last_word) begin
`ifdef READ_CTRL_CONT_EN
              addr_next  = '0;
              state_next = ST_FETCH;
              frame_end  = 1'b1;
`else
              state_next = ST_DONE;
`endif
            end else begin
              addr_next  = addr + 12'd1;
              state_next = ST_FETCH;
            end
          end else begin
            idx_next    = idx + IDX_W'(1);
            s_data_next = word_q[7:0];
            word_next   = word_q >> 8;
          end
        end
      end
      ST_DONE: begin
        addr_next  = '0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Registered outputs, computed from the next state so that each output
  // lines up with the state it describes.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      addr     <= '0;
      clk_read <= 1'b0;
      s_data   <= '0;
      s_valid  <= 1'b0;
      s_last   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      addr     <= addr_next;
      clk_read <= (state_next == ST_FETCH);
      s_data   <= s_data_next;
      s_valid  <= (state_next == ST_SHIFT);
      s_last   <= (state_next == ST_SHIFT) && (addr_next == ADDR_LAST) &&
                  (idx_next == IDX_LAST);
      busy     <= (state_next != ST_IDLE);
`ifdef READ_CTRL_CONT_EN
      done     <= frame_end;
`else
      done     <= (state_next == ST_DONE);
`endif
    end
  end

endmodule

// File: tb/tb_read_controller.sv
// Testbench for read_controller: cycle table for reset/latency/stall corners,
// then whole frames checked against a byte-stream reference model.
module tb_read_controller;

  localparam int LEN    = 3;
  localparam int WORD_W = 2048;
  localparam int BYTES  = WORD_W / 8;

  logic              clk_in = 1'b0;
  logic              reset  = 1'b1;
  logic              start  = 1'b0;
  logic [11:0]       addr;
  logic              clk_read;
  logic [WORD_W-1:0] p_data = '0;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready = 1'b0;
  logic              s_last;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  int seed        = 0;
  int bytes       = 0;
  int fetch_k     = 0;
  int done_cnt    = 0;
  int busy_cycles = 0;
  bit mon_en      = 1'b0;
  bit stall_prev  = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always #5 clk_in = ~clk_in;

  read_controller #(.S1_LENGTH(LEN), .WORD_W(WORD_W)) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .addr(addr),
    .clk_read(clk_read), .p_data(p_data), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .s_last(s_last), .busy(busy), .done(done)
  );

  // Frame-buffer contents: byte i of word a is (a*16 + i + seed) mod 256.
  function automatic logic [WORD_W-1:0] mem_word(input int a);
    logic [WORD_W-1:0] w;
    for (int i = 0; i < BYTES; i++) w[8*i +: 8] = 8'(a * 16 + i + seed);
    return w;
  endfunction

  // Memory read port: data appears the cycle after the strobe.
  always @(posedge clk_in) if (clk_read) p_data <= mem_word(int'(addr));

  // Reference model: the b-th byte of the stream is byte (b mod 256) of word
  // (b / 256) mod LEN.
  function automatic logic [7:0] exp_byte(input int b);
    int k;
    int i;
    k = (b / BYTES) % LEN;
    i = b % BYTES;
    return 8'(k * 16 + i + seed);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Stream monitor, sampled on the falling edge.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (clk_read) begin
        check("fetch_addr", addr, fetch_k % LEN);
        fetch_k++;
      end
      check("addr_range", addr <= 12'(LEN - 1), 1);
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++;
`ifdef READ_CTRL_CONT_EN
        check("cont_refetch", {clk_read, addr}, {1'b1, 12'd0});
`endif
      end
      if (stall_prev) begin
        check("stall_valid", s_valid, 1);
        check("stall_data", s_data, prev_data);
        check("stall_last", s_last, prev_last);
      end
      if (s_valid && s_ready) begin
        check("byte_data", s_data, exp_byte(bytes));
        check("byte_last", s_last, (bytes % (LEN * BYTES)) == (LEN * BYTES - 1));
        bytes++;
      end else if (!s_valid) begin
        check("last_idle", s_last, 0);
      end
      stall_prev = s_valid && !s_ready;
      prev_data  = s_data;
      prev_last  = s_last;
    end
  end

  // mode 0: s_ready held high; 1: s_ready 1,0,0,1 pattern;
  // 2: random s_ready plus random start pulses while busy.
  task automatic run_frame(input int mode, input int sd);
    bit timeout;
    seed = sd; bytes = 0; fetch_k = 0; done_cnt = 0; busy_cycles = 0;
    stall_prev = 1'b0; mon_en = 1'b1;
    start = 1'b1; s_ready = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    timeout = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      case (mode)
        0: s_ready = 1'b1;
        1: s_ready = (c % 4 == 0) || (c % 4 == 3);
        default: begin
          s_ready = 1'($urandom_range(0, 1));
          start   = ($urandom_range(0, 19) == 0);
        end
      endcase
      @(posedge clk_in); #1;
      if (done_cnt > 0) begin
        timeout = 1'b0;
        break;
      end
    end
    start = 1'b0;
    mon_en = 1'b0;
    check("frame_timeout", timeout, 0);
    check("frame_bytes", bytes, LEN * BYTES);
    check("done_count", done_cnt, 1);
    check("done_one_cycle", done, 0);
    if (mode == 0) check("frame_cycles", busy_cycles, LEN * (BYTES + 2) + 1);
`ifdef READ_CTRL_CONT_EN
    check("cont_fetches", fetch_k, LEN + 1);
    check("cont_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk_in); #1;
    reset = 1'b0;
`else
    check("frame_fetches", fetch_k, LEN);
    check("idle_busy", busy, 0);
    check("idle_addr", addr, 0);
    check("idle_clk_read", clk_read, 0);
`endif
  endtask

  typedef struct {
    logic       rst, st, rdy;
    logic       cr;
    logic [11:0] ad;
    logic       v;
    logic [7:0] d;
    logic       l, b, dn;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Outputs expected after the clock edge that samples each row's inputs.
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};  // reset
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};  // idle
    tbl[2]  = '{0, 1, 0, 1, 0, 0, 0, 0, 1, 0};  // start -> FETCH
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};  // WAIT
    tbl[4]  = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0};  // SHIFT, byte 0
    tbl[5]  = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0};  // stalled, byte 0 held
    tbl[6]  = '{0, 0, 1, 0, 0, 1, 1, 0, 1, 0};  // byte 0 taken
    tbl[7]  = '{0, 0, 1, 0, 0, 1, 2, 0, 1, 0};
    tbl[8]  = '{0, 1, 1, 0, 0, 1, 3, 0, 1, 0};  // start while busy ignored
    tbl[9]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0};  // reset mid-frame
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};  // idle, no done

    seed = 0;
    for (int j = 0; j < 11; j++) begin
      reset = tbl[j].rst; start = tbl[j].st; s_ready = tbl[j].rdy;
      @(posedge clk_in); #1;
      check($sformatf("tbl%0d_clk_read", j), clk_read, tbl[j].cr);
      check($sformatf("tbl%0d_addr", j), addr, tbl[j].ad);
      check($sformatf("tbl%0d_valid", j), s_valid, tbl[j].v);
      if (tbl[j].v || tbl[j].rst)
        check($sformatf("tbl%0d_data", j), s_data, tbl[j].d);
      check($sformatf("tbl%0d_last", j), s_last, tbl[j].l);
      check($sformatf("tbl%0d_busy", j), busy, tbl[j].b);
      check($sformatf("tbl%0d_done", j), done, tbl[j].dn);
    end
    start = 1'b0; reset = 1'b0;

    run_frame(0, 0);
    run_frame(1, int'($urandom_range(0, 255)));
    run_frame(2, int'($urandom_range(0, 255)));

    // Abort at byte 100 of word 1, then restart cleanly.
    seed = int'($urandom_range(0, 255));
    bytes = 0; fetch_k = 0; done_cnt = 0; stall_prev = 1'b0; mon_en = 1'b1;
    start = 1'b1; s_ready = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (bytes == BYTES + 100) break;
      @(posedge clk_in); #1;
    end
    check("abort_reach", bytes, BYTES + 100);
    check("abort_word", addr, 1);
    mon_en = 1'b0;
    reset = 1'b1; start = 1'b1;
    @(posedge clk_in); #1;
    reset = 1'b0; start = 1'b0;
    check("abort_outputs", {addr, clk_read, s_data, s_valid, s_last, busy, done}, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_in); #1;
      check("abort_no_done", done, 0);
      check("abort_idle", busy, 0);
    end
    check("abort_done_cnt", done_cnt, 0);
    run_frame(0, int'($urandom_range(0, 255)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
